// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
// melody_pkg : shared state encoding and score-entry field layout
// Revision   : 1.0
// ============================================================================
package melody_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_PLAY   = 2'd3
  } state_t;

  localparam int KEY_MSB = 15;
  localparam int KEY_LSB = 8;
  localparam int DUR_MSB = 7;
  localparam int DUR_LSB = 0;

  localparam logic [7:0] END_DUR  = 8'd0;
  localparam logic [7:0] KEY_REST = 8'd0;

endpackage
`default_nettype wire

// File: rtl/melody_score_ram.sv
`default_nettype none
// ============================================================================
// melody_score_ram : score storage, one write port, registered read port
// Revision         : 1.0
// ============================================================================
module melody_score_ram #(
  parameter int C_AW = 5
) (
  input  logic            clk,
  input  logic            wr,
  input  logic [C_AW-1:0] wadr,
  input  logic [15:0]     wdat,
  input  logic [C_AW-1:0] radr,
  output logic [15:0]     rdat
);

  logic [15:0] r_mem [2**C_AW];

  // Read-before-write: a colliding read returns the old entry
  always_ff @(posedge clk) begin
    if (wr) begin
      r_mem[wadr] <= wdat;
    end
    rdat <= r_mem[radr];
  end

endmodule
`default_nettype wire

// File: rtl/melody_seq.sv
`default_nettype none
// ============================================================================
// melody_seq : score sequencer driving the tone generator key input
// Revision   : 1.0
// ============================================================================
module melody_seq
  import melody_pkg::*;
#(
  parameter int C_FCK     = 48_000_000,
  parameter int C_TICK_HZ = 1_000,
  parameter int C_AW      = 5,
  parameter int C_GAP     = 8
) (
  input  logic            CK_i,
  input  logic            SRST_i,
  input  logic            WR_i,
  input  logic [C_AW-1:0] WADR_i,
  input  logic [15:0]     WDAT_i,
  input  logic            START_i,
  input  logic            STOP_i,
  input  logic            LOOP_i,
  output logic [7:0]      KEY_o,
  output logic            BUSY_o,
  output logic            DONE_o,
  output logic [C_AW-1:0] NOTE_IDX_o
);

  localparam int              C_TICK_DIV = C_FCK / C_TICK_HZ;
  localparam int              C_PW       = $clog2(C_TICK_DIV);
  localparam logic [C_PW-1:0] C_PSC_LAST = C_PW'(C_TICK_DIV - 1);
  localparam logic [C_AW-1:0] C_ADR_LAST = {C_AW{1'b1}};
  localparam logic [7:0]      C_GAP_W    = 8'(C_GAP);

  state_t          r_state, w_state_n;
  logic [C_AW-1:0] r_adr, w_adr_n;
  logic [C_AW-1:0] r_idx, w_idx_n;
  logic [7:0]      r_key, w_key_n;
  logic [7:0]      r_dcnt, w_dcnt_n;
  logic [C_PW-1:0] r_psc, w_psc_n;
  logic            r_done, w_done_n;
  logic            r_gap_en, w_gap_en_n;
  logic            w_finish;
  logic [15:0]     w_rd_data;
  logic [7:0]      w_rd_key, w_rd_dur;

  melody_score_ram #(
    .C_AW (C_AW)
  ) u_ram (
    .clk  (CK_i),
    .wr   (WR_i),
    .wadr (WADR_i),
    .wdat (WDAT_i),
    .radr (r_adr),
    .rdat (w_rd_data)
  );

  assign w_rd_key = w_rd_data[KEY_MSB:KEY_LSB];
  assign w_rd_dur = w_rd_data[DUR_MSB:DUR_LSB];

  always_ff @(posedge CK_i) begin
    if (SRST_i) begin
      r_state  <= ST_IDLE;
      r_adr    <= '0;
      r_idx    <= '0;
      r_key    <= KEY_REST;
      r_dcnt   <= '0;
      r_psc    <= '0;
      r_done   <= 1'b0;
      r_gap_en <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_adr    <= w_adr_n;
      r_idx    <= w_idx_n;
      r_key    <= w_key_n;
      r_dcnt   <= w_dcnt_n;
      r_psc    <= w_psc_n;
      r_done   <= w_done_n;
      r_gap_en <= w_gap_en_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_adr_n     = r_adr;
    w_idx_n     = r_idx;
    w_key_n     = r_key;
    w_dcnt_n    = r_dcnt;
    w_psc_n     = r_psc;
    w_done_n    = 1'b0;
    w_gap_en_n  = r_gap_en;
    w_finish    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_key_n = KEY_REST;
        if (START_i && !STOP_i) begin
          w_adr_n   = '0;
          w_state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_n = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_rd_dur == END_DUR) begin
          w_finish = 1'b1;
        end else begin
          w_key_n    = w_rd_key;
          w_dcnt_n   = w_rd_dur;
          w_psc_n    = '0;
          w_idx_n    = r_adr;
          w_gap_en_n = (w_rd_dur > C_GAP_W);
          w_state_n  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (r_psc == C_PSC_LAST) begin
          w_psc_n  = '0;
          w_dcnt_n = r_dcnt - 8'd1;
          // Only long notes are shortened by the articulation gap
          if (r_gap_en && (w_dcnt_n <= C_GAP_W)) begin
            w_key_n = KEY_REST;
          end
          if (r_dcnt == 8'd1) begin
            if (r_adr == C_ADR_LAST) begin
              w_finish = 1'b1;
            end else begin
              w_adr_n   = r_adr + 1'b1;
              w_state_n = ST_FETCH;
            end
          end
        end else begin
          w_psc_n = r_psc + 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // An empty score in loop mode finishes rather than spinning
    if (w_finish) begin
      if (LOOP_i && (r_adr != '0)) begin
        w_adr_n   = '0;
        w_state_n = ST_FETCH;
      end else begin
        w_done_n  = 1'b1;
        w_key_n   = KEY_REST;
        w_state_n = ST_IDLE;
      end
    end

    if (STOP_i && (r_state != ST_IDLE)) begin
      w_state_n = ST_IDLE;
      w_key_n   = KEY_REST;
      w_done_n  = 1'b0;
    end
  end

  assign KEY_o      = r_key;
  assign BUSY_o     = (r_state != ST_IDLE);
  assign DONE_o     = r_done;
  assign NOTE_IDX_o = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_melody_seq.sv
`default_nettype none
// ============================================================================
// tb_melody_seq : directed self-checking bench for melody_seq
// Revision      : 1.0
// ============================================================================
module tb_melody_seq;

  localparam int C_AW = 3;

  logic            CK = 1'b0;
  logic            SRST = 1'b1;
  logic            WR = 1'b0;
  logic [C_AW-1:0] WADR = '0;
  logic [15:0]     WDAT = '0;
  logic            START = 1'b0;
  logic            STOP = 1'b0;
  logic            LOOP = 1'b0;
  logic [7:0]      KEY;
  logic            BUSY;
  logic            DONE;
  logic [C_AW-1:0] NOTE_IDX;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int n;
  int d0;

  melody_seq #(
    .C_FCK     (1000),
    .C_TICK_HZ (100),
    .C_AW      (C_AW),
    .C_GAP     (2)
  ) dut (
    .CK_i       (CK),
    .SRST_i     (SRST),
    .WR_i       (WR),
    .WADR_i     (WADR),
    .WDAT_i     (WDAT),
    .START_i    (START),
    .STOP_i     (STOP),
    .LOOP_i     (LOOP),
    .KEY_o      (KEY),
    .BUSY_o     (BUSY),
    .DONE_o     (DONE),
    .NOTE_IDX_o (NOTE_IDX)
  );

  always #5 CK = ~CK;

  task automatic step(input int cnt = 1);
    repeat (cnt) begin
      @(posedge CK);
      #1;
      if (DONE === 1'b1) done_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] k, input logic [7:0] d);
    WR   = 1'b1;
    WADR = a[C_AW-1:0];
    WDAT = {k, d};
    step(1);
    WR   = 1'b0;
  endtask

  task automatic start();
    START = 1'b1;
    step(1);
    START = 1'b0;
  endtask

  task automatic run_len(input logic [7:0] v, output int len);
    len = 0;
    while (KEY === v && len < 200) begin
      step(1);
      len++;
    end
  endtask

  task automatic wait_done(output int len);
    len = 0;
    while (DONE !== 1'b1 && len < 200) begin
      step(1);
      len++;
    end
  endtask

  initial begin
    step(2);
    chk("rst_key", KEY, 8'h00);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_idx", NOTE_IDX, 3'd0);
    SRST = 1'b0;
    step(1);

    // Single note with gap
    wr(0, 8'h40, 8'd5);
    wr(1, 8'h00, 8'd0);
    d0 = done_cnt;
    start();
    chk("t1_key_e0", KEY, 8'h00);
    chk("t1_busy", BUSY, 1'b1);
    step(1);
    chk("t1_key_e1", KEY, 8'h00);
    step(1);
    chk("t1_key_on", KEY, 8'h40);
    chk("t1_idx", NOTE_IDX, 3'd0);
    run_len(8'h40, n);
    chk("t1_on_len", n[15:0], 16'd30);
    wait_done(n);
    chk("t1_gap_to_done", n[15:0], 16'd22);
    chk("t1_busy_end", BUSY, 1'b0);
    chk("t1_key_end", KEY, 8'h00);
    step(1);
    chk("t1_done_pulse", DONE, 1'b0);
    chk("t1_done_cnt", 16'(done_cnt - d0), 16'd1);

    // Short note without gap, then long note
    wr(0, 8'h10, 8'd2);
    wr(1, 8'h20, 8'd3);
    wr(2, 8'h00, 8'd0);
    start();
    step(2);
    chk("t2_key0", KEY, 8'h10);
    chk("t2_idx0", NOTE_IDX, 3'd0);
    run_len(8'h10, n);
    chk("t2_len0", n[15:0], 16'd22);
    chk("t2_key1", KEY, 8'h20);
    chk("t2_idx1", NOTE_IDX, 3'd1);
    run_len(8'h20, n);
    chk("t2_len1", n[15:0], 16'd10);
    wait_done(n);
    chk("t2_gap_to_done", n[15:0], 16'd22);

    // Loop mode, then release loop
    wr(0, 8'h40, 8'd5);
    wr(1, 8'h00, 8'd0);
    LOOP = 1'b1;
    d0 = done_cnt;
    start();
    step(2);
    chk("t3_key_on", KEY, 8'h40);
    run_len(8'h40, n);
    chk("t3_on_len", n[15:0], 16'd30);
    run_len(8'h00, n);
    chk("t3_off_len", n[15:0], 16'd24);
    chk("t3_key_again", KEY, 8'h40);
    chk("t3_no_done", 16'(done_cnt - d0), 16'd0);
    LOOP = 1'b0;
    run_len(8'h40, n);
    chk("t3_on_len2", n[15:0], 16'd30);
    wait_done(n);
    chk("t3_gap_to_done", n[15:0], 16'd22);
    chk("t3_done_cnt", 16'(done_cnt - d0), 16'd1);
    step(1);

    // Full RAM, no end marker
    for (int i = 0; i < 8; i++) wr(i, 8'(i + 1), 8'd1);
    start();
    step(2);
    for (int k = 1; k <= 7; k++) begin
      chk("t4_key", KEY, 16'(k));
      run_len(8'(k), n);
      chk("t4_len", n[15:0], 16'd12);
    end
    chk("t4_key8", KEY, 8'h08);
    chk("t4_idx7", NOTE_IDX, 3'd7);
    run_len(8'h08, n);
    chk("t4_len8", n[15:0], 16'd10);
    chk("t4_done", DONE, 1'b1);
    chk("t4_key_end", KEY, 8'h00);
    chk("t4_busy_end", BUSY, 1'b0);
    step(1);

    LOOP = 1'b1;
    start();
    step(2);
    for (int k = 1; k <= 8; k++) begin
      chk("t4l_key", KEY, 16'(k));
      run_len(8'(k), n);
      chk("t4l_len", n[15:0], 16'd12);
    end
    chk("t4l_wrap", KEY, 8'h01);
    chk("t4l_idx", NOTE_IDX, 3'd0);

    // Stop in PLAY
    d0 = done_cnt;
    STOP = 1'b1;
    step(1);
    STOP = 1'b0;
    LOOP = 1'b0;
    chk("t5_stop_key", KEY, 8'h00);
    chk("t5_stop_busy", BUSY, 1'b0);
    chk("t5_stop_done", DONE, 1'b0);
    step(3);
    chk("t5_stop_no_done", 16'(done_cnt - d0), 16'd0);

    // STOP and START together in IDLE
    START = 1'b1;
    STOP  = 1'b1;
    step(1);
    chk("t5_ss_busy", BUSY, 1'b0);
    step(1);
    chk("t5_ss_busy2", BUSY, 1'b0);
    chk("t5_ss_key", KEY, 8'h00);
    START = 1'b0;
    STOP  = 1'b0;

    // Reset mid-note, RAM preserved
    start();
    step(6);
    chk("t5_pre_rst_key", KEY, 8'h01);
    SRST = 1'b1;
    step(1);
    SRST = 1'b0;
    chk("t5_rst_key", KEY, 8'h00);
    chk("t5_rst_busy", BUSY, 1'b0);
    chk("t5_rst_done", DONE, 1'b0);
    chk("t5_rst_idx", NOTE_IDX, 3'd0);
    start();
    step(2);
    chk("t5_replay_key", KEY, 8'h01);
    run_len(8'h01, n);
    chk("t5_replay_len", n[15:0], 16'd12);
    chk("t5_replay_key2", KEY, 8'h02);
    STOP = 1'b1;
    step(1);
    STOP = 1'b0;

    // Empty score in loop mode
    wr(0, 8'h00, 8'd0);
    LOOP = 1'b1;
    start();
    chk("t6_key_e0", KEY, 8'h00);
    chk("t6_busy_e0", BUSY, 1'b1);
    chk("t6_done_e0", DONE, 1'b0);
    step(1);
    chk("t6_done_e1", DONE, 1'b0);
    chk("t6_key_e1", KEY, 8'h00);
    step(1);
    chk("t6_done_e2", DONE, 1'b1);
    chk("t6_busy_e2", BUSY, 1'b0);
    chk("t6_key_e2", KEY, 8'h00);
    LOOP = 1'b0;
    step(1);
    chk("t6_done_drop", DONE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/melody_seq.md
Name: melody_seq

Overview:
- Score sequencer that sits directly upstream of the tone generator and drives its 8-bit key input.
- Plays a stored list of {key, duration} entries, one after another, with a fixed duration tick.
- Inserts a short articulation gap at the end of each note so that repeated notes are heard as separate notes.
- Supports single-shot and looped playback, start/stop control, a one-cycle done pulse, and a host write port for loading the score.

Parameters:
- C_FCK, 48_000_000: clock frequency in Hz.
- C_TICK_HZ, 1_000: duration tick rate in Hz. C_TICK_DIV = C_FCK/C_TICK_HZ; must be >= 2.
- C_AW, 5: score address width. Depth = 2**C_AW entries.
- C_GAP, 8: articulation gap length in ticks.

Ports:
- CK_i  in  1  system clock.
- SRST_i  in  1  reset; synchronous, active-high.
- WR_i  in  1  score write strobe.
- WADR_i  in  C_AW  score write address.
- WDAT_i  in  16  score entry: [15:8] KEY, [7:0] DUR in ticks. DUR=0 is the end marker.
- START_i  in  1  level or pulse; sampled only in IDLE.
- STOP_i  in  1  abort playback.
- LOOP_i  in  1  at end of score, restart from address 0 instead of finishing.
- KEY_o  out  8  key code for the tone generator. 0 means silent/rest.
- BUSY_o  out  1  high in every state except IDLE.
- DONE_o  out  1  one-cycle pulse on natural (non-looped) completion.
- NOTE_IDX_o  out  C_AW  address of the entry currently playing.

Behaviour:
- Reset (SRST_i=1 at a clock edge), from any state:
  - state IDLE; KEY_o=0, BUSY_o=0, DONE_o=0, NOTE_IDX_o=0.
  - tick prescaler and duration counter cleared.
  - score RAM contents are not cleared.
- Score RAM:
  - registered read with 1-cycle latency.
  - a write takes effect on the clock edge.
  - a same-cycle read and write to the same address returns the old data.
  - writes are allowed at any time; an entry written during playback is used when that entry is next fetched.
- States:
  - IDLE:
    - KEY_o=0.
    - if START_i=1 and STOP_i=0: ADR<=0, go to FETCH.
  - FETCH:
    - RAM address = ADR.
    - go to DECODE next cycle.
  - DECODE (RAM data valid):
    - If DUR=0 (end marker):
      - if LOOP_i=1 and ADR!=0: ADR<=0, go to FETCH.
      - otherwise: DONE_o=1 for one cycle, go to IDLE. This also covers an empty score in loop mode, which stops instead of spinning.
    - If DUR!=0:
      - KEY_o<=KEY, DCNT<=DUR, prescaler<=0, NOTE_IDX_o<=ADR, go to PLAY.
  - PLAY:
    - prescaler counts 0..C_TICK_DIV-1; a tick fires when it reaches C_TICK_DIV-1.
    - on each tick DCNT decrements.
    - gap: when DUR>C_GAP and, after the decrement, DCNT<=C_GAP, KEY_o<=0. Notes with DUR<=C_GAP play with no gap.
    - on the tick where DCNT goes 1 -> 0:
      - if ADR = 2**C_AW-1, handle as an end marker (same rule as DECODE), taken directly from PLAY.
      - otherwise ADR<=ADR+1, go to FETCH.
- Timing:
  - a note occupies exactly DUR*C_TICK_DIV cycles in PLAY, plus 2 cycles of FETCH/DECODE overhead.
  - during the overhead cycles KEY_o holds its previous value (0 after a gap, else the previous key).
  - KEY_o changes 2 cycles after START_i is sampled.
- STOP_i=1 in any non-IDLE state: next state IDLE, KEY_o<=0, no DONE_o.
- STOP_i and START_i asserted together: STOP wins and the block stays in IDLE.
- START_i while BUSY_o=1: ignored.
- LOOP_i is sampled only at the end decision, so it may change freely during playback.
- Widths:
  - DCNT is 8 bits; the prescaler is sized to clog2(C_TICK_DIV).
  - ADR increments without wrap; the end-of-RAM case is handled explicitly as above.

Decomposition:
- Package melody_pkg holds:
  - state encoding for IDLE, FETCH, DECODE, PLAY.
  - field constants: KEY_MSB=15, KEY_LSB=8, DUR_MSB=7, DUR_LSB=0, END_DUR=0.
  - KEY_REST=0.
- One sub-module, melody_score_ram: 2**C_AW x 16, one write port, one registered read port.
- Sequencer FSM, prescaler and gap logic live in melody_seq.

Test Plan:
All scenarios use C_FCK=1000, C_TICK_HZ=100 (C_TICK_DIV=10), C_GAP=2, C_AW=3.
- Single note: score [0]={0x40,5}, [1]={0,0}; pulse START.
  - KEY_o=0x40 for 30 cycles, then 0 for 20 cycles.
  - DONE_o pulses once, 2 cycles after PLAY ends; BUSY_o then drops.
- Short note without gap: [0]={0x10,2}, [1]={0x20,3}, [2]=end.
  - KEY_o=0x10 for 20 cycles with no gap.
  - then KEY_o=0x20 for 10 cycles followed by a 20-cycle gap.
  - NOTE_IDX_o reads 0, then 1.
- Loop: same score as the single-note test, LOOP_i=1.
  - KEY_o=0x40 recurs every 54 cycles.
  - DONE_o never pulses.
  - clearing LOOP_i makes the block finish after the current pass, with one DONE_o pulse.
- Full RAM, no end marker: all 8 entries {n+1,1}.
  - plays keys 1..8 in order, then DONE_o.
  - with LOOP_i=1, wraps back to key 1.
- Stop and reset mid-note:
  - STOP_i in PLAY: KEY_o=0 and BUSY_o=0 on the next cycle, with no DONE_o.
  - STOP_i together with START_i in IDLE: the block stays in IDLE.
  - SRST_i mid-note gives the same outputs as STOP_i, and the RAM contents are preserved: a following START replays the same score.
- Empty score: [0]=end, LOOP_i=1, START.
  - DONE_o pulses 2 cycles after START; the block returns to IDLE with KEY_o=0 throughout.
